// File: rtl/button_event_decoder.sv
// Classifies a debounced push-button level into single-cycle press, release,
// short-click, double-click and long-press events plus a held level.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | button released, no click pending
// S_PRESS1 | first press in progress, timing toward a long press
// S_LONG   | long press already reported, waiting for the release
// S_WAIT2  | first short press released, double-click window open
// S_PRESS2 | second press in progress, timing toward a long press
module button_event_decoder #(
   parameter int LONG_CYCLES = 100_000_000,
   parameter int DBL_CYCLES  = 30_000_000,
   parameter int CNT_W       = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_click,
   output logic double_click,
   output logic long_press,
   output logic held
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS1 = 3'd1,
      S_LONG   = 3'd2,
      S_WAIT2  = 3'd3,
      S_PRESS2 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             pb_d;
   logic             rise;
   logic             low;
   logic             press_nxt;
   logic             release_nxt;
   logic             short_nxt;
   logic             double_nxt;
   logic             long_nxt;
   logic             held_nxt;

   assign rise = pb_in & ~pb_d;
   assign low  = ~pb_in;

   // A level change is tested before the terminal count so it always wins.
   always_comb begin
      state_nxt   = state;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      short_nxt   = 1'b0;
      double_nxt  = 1'b0;
      long_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) begin
               state_nxt = S_PRESS1;
               press_nxt = 1'b1;
            end
         end
         S_PRESS1: begin
            if (low) begin
               state_nxt   = S_WAIT2;
               release_nxt = 1'b1;
            end else if (cnt == LONG_TC) begin
               state_nxt = S_LONG;
               long_nxt  = 1'b1;
            end
         end
         S_LONG: begin
            if (low) begin
               state_nxt   = S_IDLE;
               release_nxt = 1'b1;
            end
         end
         S_WAIT2: begin
            if (pb_in) begin
               state_nxt = S_PRESS2;
               press_nxt = 1'b1;
            end else if (cnt == DBL_TC) begin
               state_nxt = S_IDLE;
               short_nxt = 1'b1;
            end
         end
         S_PRESS2: begin
            if (low) begin
               state_nxt   = S_IDLE;
               release_nxt = 1'b1;
               double_nxt  = 1'b1;
            end else if (cnt == LONG_TC) begin
               state_nxt = S_LONG;
               long_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      held_nxt = (state_nxt == S_PRESS1) || (state_nxt == S_PRESS2) ||
                 (state_nxt == S_LONG);
   end

   // pb_d resets high so a button held through reset cannot look like a rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         pb_d          <= 1'b1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_click   <= 1'b0;
         double_click  <= 1'b0;
         long_press    <= 1'b0;
         held          <= 1'b0;
      end else begin
         state         <= state_nxt;
         pb_d          <= pb_in;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         short_click   <= short_nxt;
         double_click  <= double_nxt;
         long_press    <= long_nxt;
         held          <= held_nxt;
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: button waveforms are classified into
// expected events by an interval-based reference model and compared per cycle.
module tb_button_event_decoder;

   localparam int LONG = 20;
   localparam int DBL  = 10;
   localparam int MAXN = 1024;
   localparam int B_PRESS = 5, B_REL = 4, B_SHORT = 3, B_DBL = 2, B_LONG = 1, B_HELD = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pb_in = 1'b0;
   logic press_pulse, release_pulse, short_click, double_click, long_press, held;
   logic [5:0] obs;

   int errors = 0;
   int checks = 0;

   bit       wav[MAXN];
   bit [5:0] exp_v[MAXN];
   int       n;
   int       tally[6];

   button_event_decoder #(.LONG_CYCLES(LONG), .DBL_CYCLES(DBL), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .short_click(short_click), .double_click(double_click),
      .long_press(long_press), .held(held)
   );

   always #5 clk = ~clk;

   assign obs = {press_pulse, release_pulse, short_click, double_click, long_press, held};

   function automatic void mark(input int idx, input int b);
      if (idx >= 0 && idx < n) exp_v[idx][b] = 1'b1;
   endfunction

   // Walks the waveform press by press: each press is a run of high samples
   // preceded by a low one (the sample before edge 0 counts as high, as after
   // reset). Events are placed by arithmetic on run starts and lengths.
   function automatic void build_model();
      int  e, p, h, r_pend;
      bit  prev, pend, second;
      for (int i = 0; i < MAXN; i++) exp_v[i] = '0;
      e = 0; prev = 1'b1; pend = 1'b0; r_pend = 0;
      while (e < n) begin
         if (wav[e] && !prev) begin
            p = e; h = 0;
            while (e < n && wav[e]) begin h++; e++; end
            second = pend && (p - r_pend <= DBL);
            if (pend && !second) mark(r_pend + DBL, B_SHORT);
            pend = 1'b0;
            mark(p, B_PRESS);
            for (int k = p; k < p + h; k++) mark(k, B_HELD);
            mark(p + h, B_REL);
            if (h > LONG) mark(p + LONG, B_LONG);
            else if (second) mark(p + h, B_DBL);
            else begin pend = 1'b1; r_pend = p + h; end
            prev = 1'b1;
         end else begin
            prev = wav[e];
            e++;
         end
      end
      if (pend) mark(r_pend + DBL, B_SHORT);
   endfunction

   task automatic add(input bit v, input int len);
      for (int i = 0; i < len; i++) begin wav[n] = v; n++; end
   endtask

   task automatic step(input bit v);
      @(negedge clk);
      pb_in = v;
      @(posedge clk);
      #1;
      for (int b = 0; b < 6; b++) tally[b] += int'(obs[b]);
   endtask

   task automatic apply_reset(input bit v);
      @(negedge clk);
      rst_n = 1'b0;
      pb_in = v;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int b = 0; b < 6; b++) tally[b] = 0;
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      checks++;
      if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=000000", obs); end
      apply_reset(1'b1);
      checks++;
      if (obs !== 6'b0) begin errors++; $display("FAIL reset_held_outputs got=%b exp=000000", obs); end
      repeat (4) step(1'b1);
      checks++;
      if (tally[B_PRESS] != 0 || tally[B_HELD] != 0) begin
         errors++;
         $display("FAIL reset_held_no_press presses=%0d held=%0d exp=0/0", tally[B_PRESS], tally[B_HELD]);
      end
   endtask

   task automatic test_short_click();
      n = 0; add(0, 3); add(1, 5); add(0, 15); build_model(); apply_reset(1'b0);
      for (int e = 0; e < n; e++) begin
         step(wav[e]); checks++;
         if (obs !== exp_v[e]) begin errors++; $display("FAIL short_click cyc=%0d got=%b exp=%b", e, obs, exp_v[e]); end
      end
      checks++;
      if (tally[B_SHORT] != 1 || tally[B_DBL] != 0 || tally[B_LONG] != 0 || tally[B_HELD] != 5) begin
         errors++;
         $display("FAIL short_click_tally short=%0d dbl=%0d long=%0d held=%0d exp=1/0/0/5",
                  tally[B_SHORT], tally[B_DBL], tally[B_LONG], tally[B_HELD]);
      end
   endtask

   task automatic test_long_press();
      n = 0; add(0, 3); add(1, 25); add(0, 15); build_model(); apply_reset(1'b0);
      for (int e = 0; e < n; e++) begin
         step(wav[e]); checks++;
         if (obs !== exp_v[e]) begin errors++; $display("FAIL long_press cyc=%0d got=%b exp=%b", e, obs, exp_v[e]); end
      end
      checks++;
      if (tally[B_LONG] != 1 || tally[B_SHORT] != 0 || tally[B_DBL] != 0 || tally[B_REL] != 1) begin
         errors++;
         $display("FAIL long_press_tally long=%0d short=%0d dbl=%0d rel=%0d exp=1/0/0/1",
                  tally[B_LONG], tally[B_SHORT], tally[B_DBL], tally[B_REL]);
      end
   endtask

   task automatic test_double_click();
      n = 0; add(0, 3); add(1, 5); add(0, 4); add(1, 5); add(0, 15); build_model(); apply_reset(1'b0);
      for (int e = 0; e < n; e++) begin
         step(wav[e]); checks++;
         if (obs !== exp_v[e]) begin errors++; $display("FAIL double_click cyc=%0d got=%b exp=%b", e, obs, exp_v[e]); end
      end
      checks++;
      if (tally[B_PRESS] != 2 || tally[B_DBL] != 1 || tally[B_SHORT] != 0) begin
         errors++;
         $display("FAIL double_click_tally press=%0d dbl=%0d short=%0d exp=2/1/0",
                  tally[B_PRESS], tally[B_DBL], tally[B_SHORT]);
      end
   endtask

   task automatic test_window_boundary();
      for (int gap = DBL; gap <= DBL + 1; gap++) begin
         n = 0; add(0, 3); add(1, 5); add(0, gap); add(1, 5); add(0, 15); build_model(); apply_reset(1'b0);
         for (int e = 0; e < n; e++) begin
            step(wav[e]); checks++;
            if (obs !== exp_v[e]) begin
               errors++; $display("FAIL window_gap%0d cyc=%0d got=%b exp=%b", gap, e, obs, exp_v[e]);
            end
         end
         checks++;
         if ((gap == DBL && (tally[B_DBL] != 1 || tally[B_SHORT] != 0)) ||
             (gap != DBL && (tally[B_DBL] != 0 || tally[B_SHORT] != 2))) begin
            errors++;
            $display("FAIL window_gap%0d_tally dbl=%0d short=%0d", gap, tally[B_DBL], tally[B_SHORT]);
         end
      end
   endtask

   task automatic test_long_second();
      n = 0; add(0, 3); add(1, 5); add(0, 4); add(1, 22); add(0, 15); build_model(); apply_reset(1'b0);
      for (int e = 0; e < n; e++) begin
         step(wav[e]); checks++;
         if (obs !== exp_v[e]) begin errors++; $display("FAIL long_second cyc=%0d got=%b exp=%b", e, obs, exp_v[e]); end
      end
      checks++;
      if (tally[B_LONG] != 1 || tally[B_SHORT] != 0 || tally[B_DBL] != 0) begin
         errors++;
         $display("FAIL long_second_tally long=%0d short=%0d dbl=%0d exp=1/0/0",
                  tally[B_LONG], tally[B_SHORT], tally[B_DBL]);
      end
   endtask

   task automatic test_reset_mid_press();
      apply_reset(1'b0);
      repeat (3) step(1'b0);
      repeat (4) step(1'b1);
      checks++;
      if (held !== 1'b1) begin errors++; $display("FAIL mid_reset_pre_held got=%b exp=1", held); end
      apply_reset(1'b1);
      checks++;
      if (obs !== 6'b0) begin errors++; $display("FAIL mid_reset_outputs got=%b exp=000000", obs); end
      n = 0; add(1, 3); add(0, 4); add(1, 3); add(0, 15); build_model();
      for (int e = 0; e < n; e++) begin
         step(wav[e]); checks++;
         if (obs !== exp_v[e]) begin errors++; $display("FAIL mid_reset cyc=%0d got=%b exp=%b", e, obs, exp_v[e]); end
      end
      checks++;
      if (tally[B_REL] != 1 || tally[B_PRESS] != 1 || tally[B_SHORT] != 1) begin
         errors++;
         $display("FAIL mid_reset_tally rel=%0d press=%0d short=%0d exp=1/1/1",
                  tally[B_REL], tally[B_PRESS], tally[B_SHORT]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         n = 0;
         add(0, int'($urandom_range(1, 12)));
         while (n < 400) begin
            add(1, int'($urandom_range(1, 26)));
            add(0, int'($urandom_range(1, 14)));
         end
         add(0, 15);
         build_model(); apply_reset(1'b0);
         for (int e = 0; e < n; e++) begin
            step(wav[e]); checks++;
            if (obs !== exp_v[e]) begin
               errors++; $display("FAIL random%0d cyc=%0d got=%b exp=%b", it, e, obs, exp_v[e]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_short_click();
      test_long_press();
      test_double_click();
      test_window_boundary();
      test_long_second();
      test_reset_mid_press();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
